// File: rtl/spectrum_bar_builder_pkg.sv
// spectrum_bar_builder_pkg: shared default sizes, derived-size helpers, FSM encoding and
// the shift-then-saturate height function used by spectrum_bar_builder.
package spectrum_bar_builder_pkg;

    localparam int unsigned DEF_ADDR_SIZE   = 10;
    localparam int unsigned DEF_HEIGHT_SIZE = 9;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    function automatic int unsigned bin_count(input int unsigned addr_size);
        return 32'd1 << addr_size;
    endfunction

    function automatic int unsigned max_height(input int unsigned height_size);
        return (32'd1 << height_size) - 32'd1;
    endfunction

    // Magnitudes wider than the bar clamp at full scale instead of wrapping.
    function automatic logic [31:0] sat_shift(input logic [31:0] mag,
                                              input int unsigned shift,
                                              input int unsigned height_size);
        logic [31:0] h;
        logic [31:0] h_max;
        h     = mag >> shift;
        h_max = max_height(height_size);
        return (h > h_max) ? h_max : h;
    endfunction

endpackage

// File: rtl/spectrum_peak_ram.sv
// spectrum_peak_ram: simple dual-port peak-hold RAM, synchronous write, one-cycle read latency.
// Only present in the PEAK_HOLD_EN build; read-during-write returns the old word.
`ifdef PEAK_HOLD_EN
module spectrum_peak_ram #(
    parameter int unsigned ADDR_SIZE   = 10,
    parameter int unsigned HEIGHT_SIZE = 9
) (
    input  logic                   clk_i,
    input  logic                   we_i,
    input  logic [ADDR_SIZE-1:0]   waddr_i,
    input  logic [HEIGHT_SIZE-1:0] wdata_i,
    input  logic [ADDR_SIZE-1:0]   raddr_i,
    output logic [HEIGHT_SIZE-1:0] rdata_o
);

    logic [HEIGHT_SIZE-1:0] mem_q [0:(1 << ADDR_SIZE)-1];

    // NOTE: the array has no reset so it maps onto block RAM; the parent's clear sweep zeroes it.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_o <= mem_q[raddr_i];
    end

endmodule
`endif

// File: rtl/spectrum_bar_builder.sv
// spectrum_bar_builder: FFT bin magnitude -> saturated bar height, one VRAM write per bin.
// Define PEAK_HOLD_EN for per-bin peak hold with frame decay; otherwise heights pass through.
module spectrum_bar_builder
    import spectrum_bar_builder_pkg::*;
#(
    parameter int unsigned WORD_SIZE    = 16,
    parameter int unsigned ADDR_SIZE    = DEF_ADDR_SIZE,
    parameter int unsigned HEIGHT_SIZE  = DEF_HEIGHT_SIZE,
    parameter int unsigned SHIFT        = 6,
    parameter int unsigned DECAY        = 2,
    parameter int unsigned DECAY_FRAMES = 1
) (
    input  logic                   inClock,
    input  logic                   reset,
    input  logic                   inValid,
    input  logic [ADDR_SIZE-1:0]   sampleNumber,
    input  logic [WORD_SIZE-1:0]   inData,
    output logic                   busy,
    output logic                   outValid,
    output logic [ADDR_SIZE-1:0]   outAddr,
    output logic [HEIGHT_SIZE-1:0] outData,
    output logic                   frameDone
);

    localparam logic [ADDR_SIZE-1:0] LAST_BIN = ADDR_SIZE'(bin_count(ADDR_SIZE) - 1);

    if (DECAY_FRAMES < 1 || DECAY > max_height(HEIGHT_SIZE)) begin : g_bad_decay_cfg
        $error("spectrum_bar_builder: DECAY_FRAMES must be >= 1 and DECAY must fit in a bar height");
    end

    state_e                 state_q;
    logic                   busy_q;
    logic                   s0_valid_q, s0_last_q;
    logic [ADDR_SIZE-1:0]   s0_addr_q;
    logic [HEIGHT_SIZE-1:0] s0_h_q;
    logic                   out_valid_q, out_last_q, frame_done_q;
    logic [ADDR_SIZE-1:0]   out_addr_q;
    logic [HEIGHT_SIZE-1:0] out_data_q;
    logic [HEIGHT_SIZE-1:0] h_w, result_w;
    logic                   accept_w, last_w;

    assign accept_w = inValid && (state_q == ST_RUN);
    assign last_w   = (sampleNumber == LAST_BIN);
    assign h_w      = HEIGHT_SIZE'(sat_shift(32'(inData), SHIFT, HEIGHT_SIZE));

`ifdef PEAK_HOLD_EN
    localparam int unsigned          FCNT_W    = (DECAY_FRAMES > 1) ? $clog2(DECAY_FRAMES) : 1;
    localparam logic [FCNT_W-1:0]    FCNT_LAST = FCNT_W'(DECAY_FRAMES - 1);
    localparam logic [HEIGHT_SIZE-1:0] DECAY_H = HEIGHT_SIZE'(DECAY);

    logic [ADDR_SIZE-1:0]   clr_addr_q, ram_waddr_w;
    logic [FCNT_W-1:0]      frame_cnt_q;
    logic                   s0_decay_q, byp_q, ram_we_w;
    logic [HEIGHT_SIZE-1:0] byp_data_q, ram_rdata_w, ram_wdata_w, peak_w, decayed_w;

    // Frame counter only moves on the last bin, so sampling it per bin equals sampling at a frame's first bin.
    always_ff @(posedge inClock) begin
        if (reset) begin
            state_q     <= ST_CLEAR;
            busy_q      <= 1'b1;
            clr_addr_q  <= '0;
            frame_cnt_q <= '0;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    clr_addr_q <= clr_addr_q + 1'b1;
                    if (clr_addr_q == LAST_BIN) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    if (accept_w && last_w) begin
                        frame_cnt_q <= (frame_cnt_q == FCNT_LAST) ? '0 : frame_cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    // NOTE: every signal gets a default before any condition, so no path can infer a latch.
    always_comb begin
        peak_w    = byp_q ? byp_data_q : ram_rdata_w;
        decayed_w = peak_w;
        if (s0_decay_q) begin
            decayed_w = (peak_w > DECAY_H) ? peak_w - DECAY_H : '0;
        end
        result_w    = (s0_h_q > decayed_w) ? s0_h_q : decayed_w;
        ram_we_w    = (state_q == ST_CLEAR) || s0_valid_q;
        ram_waddr_w = (state_q == ST_CLEAR) ? clr_addr_q : s0_addr_q;
        ram_wdata_w = (state_q == ST_CLEAR) ? '0 : result_w;
    end

    spectrum_peak_ram #(
        .ADDR_SIZE   (ADDR_SIZE),
        .HEIGHT_SIZE (HEIGHT_SIZE)
    ) u_peak_ram (
        .clk_i   (inClock),
        .we_i    (ram_we_w),
        .waddr_i (ram_waddr_w),
        .wdata_i (ram_wdata_w),
        .raddr_i (sampleNumber),
        .rdata_o (ram_rdata_w)
    );
`else
    always_ff @(posedge inClock) begin
        if (reset) begin
            state_q <= ST_CLEAR;
            busy_q  <= 1'b1;
        end else if (state_q == ST_CLEAR) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b0;
        end
    end

    assign result_w = s0_h_q;
`endif

    // NOTE: non-blocking assignments so each stage captures the previous cycle's values of the others.
    always_ff @(posedge inClock) begin
        if (reset) begin
            s0_valid_q   <= 1'b0;
            s0_last_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_addr_q   <= '0;
            out_data_q   <= '0;
            frame_done_q <= 1'b0;
`ifdef PEAK_HOLD_EN
            byp_q        <= 1'b0;
`endif
        end else begin
            s0_valid_q   <= accept_w;
            s0_last_q    <= accept_w && last_w;
            s0_addr_q    <= sampleNumber;
            s0_h_q       <= h_w;
            out_valid_q  <= s0_valid_q;
            out_last_q   <= s0_last_q;
            frame_done_q <= out_last_q;
            if (s0_valid_q) begin
                out_addr_q <= s0_addr_q;
                out_data_q <= result_w;
            end
`ifdef PEAK_HOLD_EN
            s0_decay_q <= (frame_cnt_q == FCNT_LAST);
            // The RAM returns the pre-write word when S0 reads what S1 writes, so carry the result across.
            byp_q      <= accept_w && s0_valid_q && (sampleNumber == s0_addr_q);
            byp_data_q <= result_w;
`endif
        end
    end

    assign busy      = busy_q;
    assign outValid  = out_valid_q;
    assign outAddr   = out_addr_q;
    assign outData   = out_data_q;
    assign frameDone = frame_done_q;

endmodule

// File: tb/tb_spectrum_bar_builder.sv
// tb_spectrum_bar_builder: directed vectors with hand-computed bar heights for spectrum_bar_builder.
// Expectations follow PEAK_HOLD_EN: PH(peak_build_value, pass_through_value).
`ifdef PEAK_HOLD_EN
`define PH(p, n) (p)
`else
`define PH(p, n) (n)
`endif

module tb_spectrum_bar_builder;

    logic        clk;
    logic        reset;
    logic        inValid;
    logic [9:0]  sampleNumber;
    logic [15:0] inData;
    logic        busy;
    logic        outValid;
    logic [9:0]  outAddr;
    logic [8:0]  outData;
    logic        frameDone;

    typedef struct {
        int due;
        int addr;
        int data;
    } exp_t;

    exp_t wq[$];
    int   fdq[$];
    exp_t mon_e;
    int   cyc;
    int   checks;
    int   errors;
    bit   run_chk;

    spectrum_bar_builder dut (
        .inClock      (clk),
        .reset        (reset),
        .inValid      (inValid),
        .sampleNumber (sampleNumber),
        .inData       (inData),
        .busy         (busy),
        .outValid     (outValid),
        .outAddr      (outAddr),
        .outData      (outData),
        .frameDone    (frameDone)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (wq.size() > 0 && wq[0].due < cyc) begin
            check("write_overdue", 32'(cyc), 32'(wq[0].due));
            wq.delete(0);
        end
        if (outValid === 1'b1) begin
            if (wq.size() == 0) begin
                check("write_unexpected", 32'(outValid), 32'd0);
            end else begin
                mon_e = wq.pop_front();
                check("write_cycle", 32'(cyc), 32'(mon_e.due));
                check("write_addr", 32'(outAddr), 32'(mon_e.addr));
                check("write_data", 32'(outData), 32'(mon_e.data));
            end
        end
        if (fdq.size() > 0 && fdq[0] < cyc) begin
            check("frame_done_overdue", 32'(cyc), 32'(fdq[0]));
            fdq.delete(0);
        end
        if (frameDone === 1'b1) begin
            if (fdq.size() == 0) check("frame_done_unexpected", 32'(frameDone), 32'd0);
            else check("frame_done_cycle", 32'(cyc), 32'(fdq.pop_front()));
        end
        if (run_chk) check("busy_in_run", 32'(busy), 32'd0);
    end

    // Called just after a rising edge; the bin is sampled on the next edge.
    task automatic send(input int addr, input int data, input int exp);
        inValid      = 1'b1;
        sampleNumber = 10'(addr);
        inData       = 16'(data);
        wq.push_back('{due: cyc + 2, addr: addr, data: exp});
        if (addr == 1023) fdq.push_back(cyc + 3);
        @(posedge clk);
        #1;
        inValid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Bins still in flight when reset is sampled must never appear.
    task automatic do_reset(input bit junk, input int exp_busy);
        int n;
        run_chk      = 1'b0;
        reset        = 1'b1;
        inValid      = junk;
        sampleNumber = 10'h3FF;
        inData       = 16'hFFFF;
        while (wq.size() > 0 && wq[wq.size()-1].due > cyc) wq.delete(wq.size() - 1);
        while (fdq.size() > 0 && fdq[fdq.size()-1] > cyc) fdq.delete(fdq.size() - 1);
        idle(2);
        check("rst_out_valid", 32'(outValid), 32'd0);
        check("rst_out_addr", 32'(outAddr), 32'd0);
        check("rst_out_data", 32'(outData), 32'd0);
        check("rst_frame_done", 32'(frameDone), 32'd0);
        check("rst_busy", 32'(busy), 32'd1);
        reset = 1'b0;
        for (n = 0; n < 4000; n++) begin
            @(negedge clk);
            if (busy !== 1'b1) break;
        end
        inValid = 1'b0;
        check("busy_cycles", 32'(n), 32'(exp_busy));
        @(posedge clk);
        #1;
        run_chk = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        cyc          = 0;
        checks       = 0;
        errors       = 0;
        run_chk      = 1'b0;
        reset        = 1'b1;
        inValid      = 1'b0;
        sampleNumber = '0;
        inData       = '0;

        do_reset(1'b0, `PH(1024, 1));
        idle(3);

        // Full frame of zero magnitudes, then frameDone.
        for (int i = 0; i < 1024; i++) send(i, 0, 0);
        idle(4);

        // Saturation and shift boundaries.
        send(5, 'hFFFF, 511);
        send(6, 6400, 100);
        send(8, 63, 0);
        send(9, 64, 1);
        send(10, 32767, 511);
        send(11, 32768, 511);
        send(1023, 0, 0);
        idle(3);

        // Peak hold with decay and the zero floor (peaks 100, 1, 3).
        send(3, 6400, 100);
        send(4, 64, 1);
        send(12, 192, 3);
        send(1023, 0, 0);
        send(3, 0, `PH(98, 0));
        send(4, 0, 0);
        send(12, 0, `PH(1, 0));
        send(1023, 0, 0);
        send(3, 0, `PH(96, 0));
        send(4, 0, 0);
        send(12, 0, 0);
        send(1023, 0, 0);
        send(3, 0, `PH(94, 0));
        send(1023, 0, 0);
        send(3, 6400, 100);
        send(1023, 0, 0);
        idle(3);

        // Back-to-back same bin must see the just-written peak; one-cycle gap reads RAM.
        send(7, 6400, 100);
        send(7, 0, `PH(98, 0));
        send(7, 0, `PH(96, 0));
        send(13, 6400, 100);
        idle(1);
        send(13, 0, `PH(98, 0));
        send(1023, 0, 0);
        send(1023, 0, 0);
        idle(4);

        // Reset mid-frame with junk inputs held during the clear.
        for (int i = 0; i < 300; i++) send(i, 'hFFFF, 511);
        do_reset(1'b1, `PH(1024, 1));
        send(3, 0, 0);
        send(5, 0, 0);
        send(7, 0, 0);
        send(1023, 0, 0);
        idle(4);

        check("pending_writes", 32'(wq.size()), 32'd0);
        check("pending_frames", 32'(fdq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spectrum_bar_builder.md
Name: spectrum_bar_builder

Overview:
Sits between the FFT output and the VGA generator's VRAM write port. Converts each FFT bin magnitude into a saturated bar height. Keeps a per-bin peak-hold memory that decays once per frame and emits one VRAM write per accepted bin. Gives the display falling-bar dynamics without touching the FFT or VGA blocks.

Parameters:
WORD_SIZE, 16, width of input magnitude (unsigned)
ADDR_SIZE, 10, bin index width; bins = 2**ADDR_SIZE
HEIGHT_SIZE, 9, bar height width; max height = 2**HEIGHT_SIZE-1
SHIFT, 6, right shift applied to magnitude before saturation
DECAY, 2, height units subtracted from a held peak per decay event
DECAY_FRAMES, 1, frames between decay events (>=1)

Ports:
inClock  input  1  sole clock; all state on rising edge
reset  input  1  synchronous, active-high
inValid  input  1  one bin presented this cycle
sampleNumber  input  ADDR_SIZE  bin index of inData
inData  input  WORD_SIZE  unsigned bin magnitude
busy  output  1  high while clearing; inputs ignored
outValid  output  1  VRAM write strobe
outAddr  output  ADDR_SIZE  VRAM address (= bin index)
outData  output  HEIGHT_SIZE  bar height to write
frameDone  output  1  one-cycle pulse after the last bin's write

Behaviour:
- Reset (synchronous, active-high): outValid=0, outAddr=0, outData=0, frameDone=0, busy=1, frame counter=0, FSM->CLEAR.
- FSM states:
  - CLEAR: writes 0 to peak RAM at address 0..2**ADDR_SIZE-1, one address per cycle; busy=1; inValid ignored, no outValid. Moves to RUN after the last address, taking 2**ADDR_SIZE cycles.
  - RUN: busy=0; accepts inValid every cycle; no backpressure. Reset in any state returns to CLEAR and restarts the sweep from 0, dropping all pipeline contents.
- Height computation: h = inData >> SHIFT; if h > 2**HEIGHT_SIZE-1, h = 2**HEIGHT_SIZE-1 (saturate, never wrap).
- Pipeline, fixed latency 2 cycles from an accepted inValid to outValid:
  - S0: issue peak RAM read at sampleNumber; register h, address and the decay flag.
  - S1: p = RAM data (forwarded, see below). If decay flag, p' = (p > DECAY) ? p-DECAY : 0, else p' = p. result = max(h, p'). Write result back to RAM and drive outValid/outAddr/outData.
- Hazard: if S1 writes the same address S0 reads in the same cycle, S0 uses the S1 result (bypass). Back-to-back identical addresses must behave as if fully sequential.
- Frame tracking:
  - A frame ends when an accepted bin has sampleNumber = 2**ADDR_SIZE-1. frameDone pulses in the cycle after that bin's outValid.
  - The frame counter counts frames modulo DECAY_FRAMES. The decay flag is 1 for all bins of a frame whose counter = DECAY_FRAMES-1 at that frame's first bin.
  - Out-of-order or repeated indices are processed normally; only index 2**ADDR_SIZE-1 advances the frame.
- inValid gaps: pipeline holds no state beyond the in-flight stages; outValid is low for the matching cycles.
- h = 0 with a held peak of 0 still issues a write (outData=0).

Optional Feature:
PEAK_HOLD_EN
- Defined: peak RAM, CLEAR sweep, decay and bypass present, as above.
- Undefined: no RAM. outData = saturated h, latency stays 2 cycles (plain register stage). CLEAR lasts 1 cycle (busy high for one cycle after reset). frameDone behaviour unchanged. DECAY/DECAY_FRAMES unused.

Decomposition:
- Shared package: bin-count and max-height constants derived from ADDR_SIZE/HEIGHT_SIZE; FSM state encoding (CLEAR, RUN); saturate-shift helper function.
- One sub-module: spectrum_peak_ram, a simple dual-port, 1-read-latency RAM of 2**ADDR_SIZE x HEIGHT_SIZE, synchronous write, inferred block RAM. Bypass logic stays in the parent.

Test Plan:
- Reset, then idle: busy high exactly 1024 cycles, then 0; outValid stays 0; a full frame of inData=0 gives 1024 writes of 0, each 2 cycles after its input, then frameDone.
- Saturation: inData=16'hFFFF at bin 5 -> outData=511. inData=64*100=6400 at bin 6 -> outData=100.
- Peak hold and decay (DECAY=2, DECAY_FRAMES=1): bin 3 = 6400 in frame 1 -> 100. Bin 3 = 0 in frames 2, 3, 4 -> 98, 96, 94. Bin 3 = 6400 again -> 100.
- Decay floor: peak 1 with DECAY=2 and zero input -> 0, and stays 0 in later frames.
- Bypass: bin 7 presented twice consecutively (6400, then 0) in a decay frame -> second write = 98. The stale RAM value must not be used.
- Reset mid-frame after 300 bins: no outValid for in-flight bins; busy for 1024 cycles; next frame bin 3 = 0 -> outData=0 (peaks cleared). Repeat all scenarios with PEAK_HOLD_EN undefined: output equals saturated h, busy high 1 cycle.
